mod_mem_icache_assoc: RTL and testbench

//  Parametrised N-way set-associative, read-only instruction cache; next generation of the fixed icache wrapper.

---
 rtl/mod_mem_icache_assoc.sv | 131 +++++++++++++
 tb/tb_mod_mem_icache_assoc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mem_icache_assoc.sv
// mod_mem_icache_assoc: N-way set-associative read-only instruction cache with line refill, round-robin replacement, flush and abort
module mod_mem_icache_assoc #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            abort_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] address_i,
  input  logic            read_i,
  output logic [XLEN-1:0] readdata_o,
  output logic            stb_o,
  output logic [XLEN-1:0] address_o,
  output logic            busy_o,
  input  logic [XLEN-1:0] memory_readdata_i,
  input  logic            memory_operation_stb_i,
  output logic [XLEN-1:0] memory_address_o,
  output logic            memory_read_o
);
  localparam int OB = $clog2(LINE_WORDS);
  localparam int OW = OB > 0 ? OB : 1;
  localparam int IB = $clog2(SETS);
  localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int AW = XLEN - 2;
  localparam int TW = AW - OB - IB;
  localparam int DA = IB + OB;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, DRAIN, RESPOND} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] lat_q;
  logic [OW-1:0] ctr_q;
  logic [WB-1:0] victim_q, hit_way, rd_way;
  logic flush_pend_q;
  logic [SETS-1:0] valid_q [WAYS];
  logic [TW-1:0] tag_q [WAYS][SETS];
  logic [XLEN-1:0] data_q [WAYS][SETS*LINE_WORDS];
  logic [WB-1:0] rr_q [SETS];
  logic [IB-1:0] idx;
  logic [TW-1:0] tag;
  logic [AW-1:0] mem_word;
  logic [XLEN-1:0] rd_word;
  logic hit, last, do_flush, accept, miss, fill_stb, stb, mem_rd;
  logic unused_ok;
  assign unused_ok = ^address_i[1:0];
  assign idx = lat_q[OB +: IB];
  assign tag = lat_q[AW-1 -: TW];
  // Line words are consecutive, so the refill address is the line base ORed with the word counter.
  assign mem_word = (lat_q & ~AW'(LINE_WORDS - 1)) | AW'(ctr_q);
  assign last = ctr_q == OW'(LINE_WORDS - 1);
  assign do_flush = flush_i | flush_pend_q;
  assign accept = state_q == IDLE && !do_flush && read_i;
  assign miss = state_q == LOOKUP && !abort_i && !hit;
  assign fill_stb = state_q == REFILL && !abort_i && memory_operation_stb_i;
  assign rd_way = state_q == LOOKUP ? hit_way : victim_q;
  assign rd_word = data_q[rd_way][lat_q[DA-1:0]];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = WB'(w);
      end
  end
  always_comb begin
    state_d = state_q;
    stb = 1'b0;
    mem_rd = 1'b0;
    case (state_q)
      IDLE:    state_d = accept ? LOOKUP : IDLE;
      LOOKUP: begin
        stb = !abort_i && hit;
        state_d = abort_i || hit ? IDLE : REFILL;
      end
      REFILL: begin
        mem_rd = 1'b1;
        if (abort_i) state_d = memory_operation_stb_i ? IDLE : DRAIN;
        else if (memory_operation_stb_i && last) state_d = RESPOND;
      end
      DRAIN: begin
        mem_rd = 1'b1;
        state_d = memory_operation_stb_i ? IDLE : DRAIN;
      end
      RESPOND: begin
        stb = !abort_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign stb_o = stb;
  assign readdata_o = stb ? rd_word : '0;
  assign address_o = stb ? {lat_q, 2'b00} : '0;
  assign memory_read_o = mem_rd;
  assign memory_address_o = mem_rd ? {mem_word, 2'b00} : '0;
  assign busy_o = state_q != IDLE || flush_pend_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      lat_q <= '0;
      ctr_q <= '0;
      victim_q <= '0;
      flush_pend_q <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      flush_pend_q <= state_q != IDLE && (flush_pend_q || flush_i);
      if (accept) lat_q <= address_i[XLEN-1:2];
      if (state_q == IDLE && do_flush)
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      if (miss) begin
        victim_q <= rr_q[idx];
        ctr_q <= '0;
      end
      if (state_q == REFILL && abort_i) valid_q[victim_q][idx] <= 1'b0;
      else if (fill_stb) begin
        ctr_q <= ctr_q + OW'(1);
        if (last) begin
          valid_q[victim_q][idx] <= 1'b1;
          rr_q[idx] <= WAYS > 1 ? rr_q[idx] + WB'(1) : '0;
        end
      end
    end
  always_ff @(posedge clk_i) begin
    if (fill_stb) data_q[victim_q][mem_word[DA-1:0]] <= memory_readdata_i;
    if (fill_stb && last) tag_q[victim_q][idx] <= tag;
  end
endmodule

// File: tb/tb_mod_mem_icache_assoc.sv
// tb_mod_mem_icache_assoc: randomized scoreboard bench with a set/way/round-robin reference model
module tb_mod_mem_icache_assoc;
  localparam int WAYS = 2;
  localparam int SETS = 64;
  localparam int LW = 4;
  logic clk_i = 0, rst_ni = 0, abort_i = 0, flush_i = 0, read_i = 0;
  logic [31:0] address_i = '0, memory_readdata_i = '0;
  logic memory_operation_stb_i = 0;
  logic [31:0] readdata_o, address_o, memory_address_o;
  logic stb_o, busy_o, memory_read_o;
  int checks = 0, fails = 0;
  int fixed_lat = -1, mem_cnt = 0, w = 0, cur_lat = 0;
  logic [31:0] mem_base = '0, prev = '0;
  logic [31:0] sb_a[$], sb_d[$];
  bit mval[SETS][WAYS];
  logic [31:0] mtag[SETS][WAYS];
  int mrr[SETS];

  mod_mem_icache_assoc #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .abort_i(abort_i), .flush_i(flush_i),
    .address_i(address_i), .read_i(read_i), .readdata_o(readdata_o), .stb_o(stb_o),
    .address_o(address_o), .busy_o(busy_o), .memory_readdata_i(memory_readdata_i),
    .memory_operation_stb_i(memory_operation_stb_i), .memory_address_o(memory_address_o),
    .memory_read_o(memory_read_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear(input bit rr_too);
    for (int s = 0; s < SETS; s++) begin
      for (int k = 0; k < WAYS; k++) mval[s][k] = 0;
      if (rr_too) mrr[s] = 0;
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    int s = int'((a >> 4) % SETS);
    for (int k = 0; k < WAYS; k++) if (mval[s][k] && mtag[s][k] == (a >> 10)) return 1;
    return 0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 200) begin
      @(posedge clk_i); #2;
      n++;
    end
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL idle_timeout: busy_o stuck at 1 after %0d cycles", n);
    end
  endtask

  task automatic start_read(input logic [31:0] a);
    wait_idle();
    mem_base = a & ~32'hF;
    mem_cnt = 0;
    read_i = 1;
    address_i = a;
    @(posedge clk_i); #2;
    read_i = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input bit flush_mid);
    int s = int'((a >> 4) % SETS);
    bit hit = model_hit(a);
    int v, n;
    sb_a.push_back({a[31:2], 2'b00});
    sb_d.push_back(mfn({a[31:2], 2'b00}));
    start_read(a);
    if (!hit) begin
      v = mrr[s];
      mtag[s][v] = a >> 10;
      mval[s][v] = 1;
      mrr[s] = (v + 1) % WAYS;
    end
    @(negedge clk_i);
    chk("hit_stb", stb_o, hit);
    if (flush_mid && !hit) begin
      @(posedge clk_i); #2 flush_i = 1;
      @(posedge clk_i); #2 flush_i = 0;
      n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (!stb_o && n < 100);
      chk("flush_refill_stb", stb_o, 1);
      @(negedge clk_i);
      chk("flush_busy", busy_o, 1);
      model_clear(0);
    end
    wait_idle();
    chk("mem_reads", mem_cnt, hit ? 0 : LW);
  endtask

  task automatic do_abort(input logic [31:0] a);
    int s = int'((a >> 4) % SETS);
    int n = 0;
    fixed_lat = 2;
    start_read(a);
    mval[s][mrr[s]] = 0;
    @(negedge clk_i);
    chk("abort_lookup_miss", stb_o, 0);
    while (mem_cnt < 1 && n < 100) begin
      @(posedge clk_i); #2;
      n++;
    end
    @(posedge clk_i); #2;
    chk("abort_mem_rd", memory_read_o, 1);
    chk("abort_addr", memory_address_o, mem_base + 4);
    abort_i = 1;
    @(posedge clk_i); #2;
    abort_i = 0;
    chk("drain_mem_rd", memory_read_o, 1);
    chk("drain_addr", memory_address_o, mem_base + 4);
    wait_idle();
    chk("abort_reads", mem_cnt, 2);
    fixed_lat = -1;
  endtask

  task automatic do_reset_mid(input logic [31:0] a);
    fixed_lat = 2;
    start_read(a);
    @(posedge clk_i); #2;
    chk("pre_rst_mem_rd", memory_read_o, 1);
    rst_ni = 0;
    #1;
    chk("rst_mem_rd", memory_read_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_stb", stb_o, 0);
    @(posedge clk_i); #2;
    rst_ni = 1;
    model_clear(1);
    fixed_lat = -1;
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    if (!rst_ni || !memory_read_o) begin
      memory_operation_stb_i = 0;
      w = 0;
    end else begin
      if (w == 0) begin
        cur_lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 2));
        prev = memory_address_o;
      end else chk("mem_addr_hold", memory_address_o, prev);
      if (w >= cur_lat) begin
        chk("mem_addr", memory_address_o, mem_base + 32'(4 * mem_cnt));
        memory_readdata_i = mfn(memory_address_o);
        memory_operation_stb_i = 1;
        mem_cnt++;
        w = 0;
      end else begin
        memory_operation_stb_i = 0;
        w++;
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_ni && stb_o) begin
      chk("stb_with_abort", abort_i, 0);
      if (sb_a.size() == 0) chk("stb_unexpected", stb_o, 0);
      else begin
        chk("resp_addr", address_o, sb_a.pop_front());
        chk("resp_data", readdata_o, sb_d.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    model_clear(1);
    #12;
    chk("reset_stb", stb_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_mem_rd", memory_read_o, 0);
    chk("reset_rdata", readdata_o, 0);
    chk("reset_addr", address_o, 0);
    chk("reset_mem_addr", memory_address_o, 0);
    @(posedge clk_i); #2 rst_ni = 1;
    do_read(32'h100, 0);
    do_read(32'h108, 0);
    do_read(32'h10F, 0);
    do_read(32'h0000, 0);
    do_read(32'h4000, 0);
    do_read(32'h8000, 0);
    do_read(32'h4000, 0);
    do_read(32'h0000, 0);
    do_abort(32'h2040);
    do_read(32'h2044, 0);
    do_read(32'h3080, 1);
    do_read(32'h3080, 0);
    do_read(32'h500, 0);
    do_read(32'h504, 0);
    do_reset_mid(32'h600);
    do_read(32'h500, 0);
    for (int i = 0; i < 60; i++) begin
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        flush_i = 1;
        @(posedge clk_i); #2 flush_i = 0;
        model_clear(0);
      end
      do_read(a, $urandom_range(0, 5) == 0);
    end
    wait_idle();
    repeat (3) @(posedge clk_i);
    chk("sb_empty", sb_a.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
